alu_share_arbiter: RTL and testbench

Two-port arbiter that time-shares the single combinational 32-bit ALU of the multi-cycle CPU between two requesters: port 0 (main datapath EXE stage) and port 1 (branch/address helper). Each port issues an operation with a valid/ready handshake. The arbiter grants the ALU to one port per cycle using round-robin priority, drives the ALU inputs, and captures the result into a per-port response register. Each response register holds its result until that port accepts it.

---
 rtl/alu_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Time-shares one combinational ALU between two requesters (port 0: EXE
//   stage, port 1: branch/address helper). One grant per cycle, round-robin
//   between ports when both contend. The ALU result is captured into a
//   per-port response register that holds until that port consumes it.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,

   input  logic             req_valid_0,
   input  logic [2:0]       req_op_0,
   input  logic [WIDTH-1:0] req_a_0,
   input  logic [WIDTH-1:0] req_b_0,
   output logic             req_ready_0,

   input  logic             req_valid_1,
   input  logic [2:0]       req_op_1,
   input  logic [WIDTH-1:0] req_a_1,
   input  logic [WIDTH-1:0] req_b_1,
   output logic             req_ready_1,

   output logic             rsp_valid_0,
   output logic [WIDTH-1:0] rsp_result_0,
   output logic             rsp_zero_0,
   input  logic             rsp_ready_0,

   output logic             rsp_valid_1,
   output logic [WIDTH-1:0] rsp_result_1,
   output logic             rsp_zero_1,
   input  logic             rsp_ready_1,

   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,

   output logic             busy
);

   // Round-robin pointer: names the port that wins when both contend.
   typedef enum logic {
      PRIO_P0 = 1'b0,
      PRIO_P1 = 1'b1
   } prio_t;

   prio_t prio;
   prio_t prio_next;

   logic elig_0;
   logic elig_1;
   logic grant_0;
   logic grant_1;

   // A port may issue when its response slot is free or being drained now.
   always_comb begin
      elig_0 = req_valid_0 && (!rsp_valid_0 || rsp_ready_0);
      elig_1 = req_valid_1 && (!rsp_valid_1 || rsp_ready_1);
   end

   // Grant selection; reset suppresses any grant so the operation is dropped.
   always_comb begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      if (!Reset) begin
         if (elig_0 && elig_1) begin
            if (prio == PRIO_P0) begin
               grant_0 = 1'b1;
            end else begin
               grant_1 = 1'b1;
            end
         end else begin
            grant_0 = elig_0;
            grant_1 = elig_1;
         end
      end
   end

   // Priority register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         prio <= PRIO_P0;
      end else begin
         prio <= prio_next;
      end
   end

   // Next priority: after a grant, favour the other port.
   always_comb begin
      prio_next = prio;
      if (grant_0) begin
         prio_next = PRIO_P1;
      end else if (grant_1) begin
         prio_next = PRIO_P0;
      end
   end

   // Handshake and ALU input mux; ALU inputs idle at zero without a grant.
   always_comb begin
      req_ready_0 = grant_0;
      req_ready_1 = grant_1;
      busy        = grant_0 || grant_1;
      alu_op      = '0;
      alu_a       = '0;
      alu_b       = '0;
      if (grant_0) begin
         alu_op = req_op_0;
         alu_a  = req_a_0;
         alu_b  = req_b_0;
      end else if (grant_1) begin
         alu_op = req_op_1;
         alu_a  = req_a_1;
         alu_b  = req_b_1;
      end
   end

   // Port 0 response register: capture on grant, clear when consumed.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         rsp_valid_0  <= 1'b0;
         rsp_result_0 <= '0;
         rsp_zero_0   <= 1'b0;
      end else if (grant_0) begin
         rsp_valid_0  <= 1'b1;
         rsp_result_0 <= alu_result;
         rsp_zero_0   <= alu_zero;
      end else if (rsp_ready_0) begin
         rsp_valid_0  <= 1'b0;
      end
   end

   // Port 1 response register: capture on grant, clear when consumed.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         rsp_valid_1  <= 1'b0;
         rsp_result_1 <= '0;
         rsp_zero_1   <= 1'b0;
      end else if (grant_1) begin
         rsp_valid_1  <= 1'b1;
         rsp_result_1 <= alu_result;
         rsp_zero_1   <= alu_zero;
      end else if (rsp_ready_1) begin
         rsp_valid_1  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed vector table plus randomized
// traffic checked against a behavioural model of the arbitration rules.
module tb_alu_share_arbiter;

   localparam int unsigned W = 32;

   logic          CLK = 1'b0;
   logic          Reset;
   logic          req_valid_0, req_valid_1;
   logic [2:0]    req_op_0, req_op_1;
   logic [W-1:0]  req_a_0, req_a_1, req_b_0, req_b_1;
   logic          req_ready_0, req_ready_1;
   logic          rsp_valid_0, rsp_valid_1;
   logic [W-1:0]  rsp_result_0, rsp_result_1;
   logic          rsp_zero_0, rsp_zero_1;
   logic          rsp_ready_0, rsp_ready_1;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic          alu_zero;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .CLK(CLK), .Reset(Reset),
      .req_valid_0(req_valid_0), .req_op_0(req_op_0), .req_a_0(req_a_0), .req_b_0(req_b_0), .req_ready_0(req_ready_0),
      .req_valid_1(req_valid_1), .req_op_1(req_op_1), .req_a_1(req_a_1), .req_b_1(req_b_1), .req_ready_1(req_ready_1),
      .rsp_valid_0(rsp_valid_0), .rsp_result_0(rsp_result_0), .rsp_zero_0(rsp_zero_0), .rsp_ready_0(rsp_ready_0),
      .rsp_valid_1(rsp_valid_1), .rsp_result_1(rsp_result_1), .rsp_zero_1(rsp_zero_1), .rsp_ready_1(rsp_ready_1),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Simple ALU attached to the arbiter.
   function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   assign alu_result = alu_f(alu_op, alu_a, alu_b);
   assign alu_zero   = (alu_result == '0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        v0; logic [2:0] op0; logic [31:0] a0; logic [31:0] b0; logic rr0;
      logic        v1; logic [2:0] op1; logic [31:0] a1; logic [31:0] b1; logic rr1;
      logic        e_rdy0; logic e_rdy1; logic e_busy;
      logic        e_v0; logic [31:0] e_r0; logic e_z0;
      logic        e_v1; logic [31:0] e_r1; logic e_z1;
   } vec_t;

   function automatic vec_t mk(input int rst,
                               input int v0, input int op0, input int a0, input int b0, input int rr0,
                               input int v1, input int op1, input int a1, input int b1, input int rr1,
                               input int rdy0, input int rdy1, input int bsy,
                               input int ev0, input int er0, input int ez0,
                               input int ev1, input int er1, input int ez1);
      vec_t v;
      v.rst = 1'(rst);
      v.v0 = 1'(v0); v.op0 = 3'(op0); v.a0 = 32'(a0); v.b0 = 32'(b0); v.rr0 = 1'(rr0);
      v.v1 = 1'(v1); v.op1 = 3'(op1); v.a1 = 32'(a1); v.b1 = 32'(b1); v.rr1 = 1'(rr1);
      v.e_rdy0 = 1'(rdy0); v.e_rdy1 = 1'(rdy1); v.e_busy = 1'(bsy);
      v.e_v0 = 1'(ev0); v.e_r0 = 32'(er0); v.e_z0 = 1'(ez0);
      v.e_v1 = 1'(ev1); v.e_r1 = 32'(er1); v.e_z1 = 1'(ez1);
      return v;
   endfunction

   task automatic drive(input logic rst,
                        input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic rr0,
                        input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic rr1);
      Reset = rst;
      req_valid_0 = v0; req_op_0 = op0; req_a_0 = a0; req_b_0 = b0; rsp_ready_0 = rr0;
      req_valid_1 = v1; req_op_1 = op1; req_a_1 = a1; req_b_1 = b1; rsp_ready_1 = rr1;
   endtask

   vec_t tbl[15];

   // Behavioural model state for the random phase.
   logic          mv[2];
   logic [31:0]   mr[2];
   logic          mz[2];
   int            mprio;
   logic          pv[2];
   logic [2:0]    pop[2];
   logic [31:0]   pa[2];
   logic [31:0]   pb[2];
   logic          rr[2];

   initial begin
      // Directed vectors, applied in order from the post-reset state.
      //            rst  v0 op  a     b    rr0  v1 op a     b     rr1  rdy0 rdy1 busy  v0 r0   z0  v1 r1    z1
      tbl[0]  = mk(0,   1, 0,  5,    7,   0,   0, 0, 0,    0,    0,   1,   0,   1,    1, 12,  0,  0, 0,    0);
      tbl[1]  = mk(0,   0, 0,  0,    0,   0,   0, 0, 0,    0,    0,   0,   0,   0,    1, 12,  0,  0, 0,    0);
      tbl[2]  = mk(0,   0, 0,  0,    0,   0,   1, 1, 3,    3,    0,   0,   1,   1,    1, 12,  0,  1, 0,    1);
      tbl[3]  = mk(0,   0, 0,  0,    0,   1,   0, 0, 0,    0,    1,   0,   0,   0,    0, 12,  0,  0, 0,    1);
      tbl[4]  = mk(0,   1, 0,  10,   1,   1,   1, 2, 'hF0, 'h3C, 1,   1,   0,   1,    1, 11,  0,  0, 0,    1);
      tbl[5]  = mk(0,   1, 0,  20,   2,   1,   1, 2, 'hF0, 'h3C, 1,   0,   1,   1,    0, 11,  0,  1, 'h30, 0);
      tbl[6]  = mk(0,   1, 0,  20,   2,   1,   1, 4, 7,    7,    1,   1,   0,   1,    1, 22,  0,  0, 'h30, 0);
      tbl[7]  = mk(0,   1, 0,  1,    1,   1,   1, 4, 7,    7,    1,   0,   1,   1,    0, 22,  0,  1, 0,    1);
      tbl[8]  = mk(0,   1, 0,  100,  1,   0,   1, 0, 1,    2,    1,   1,   0,   1,    1, 101, 0,  0, 0,    1);
      tbl[9]  = mk(0,   1, 0,  200,  0,   0,   1, 0, 1,    2,    1,   0,   1,   1,    1, 101, 0,  1, 3,    0);
      tbl[10] = mk(0,   1, 0,  200,  0,   0,   1, 1, 9,    4,    1,   0,   1,   1,    1, 101, 0,  1, 5,    0);
      tbl[11] = mk(0,   1, 0,  200,  0,   1,   0, 0, 0,    0,    1,   1,   0,   1,    1, 200, 0,  0, 5,    0);
      tbl[12] = mk(0,   1, 0,  4,    4,   1,   0, 0, 0,    0,    1,   1,   0,   1,    1, 8,   0,  0, 5,    0);
      tbl[13] = mk(1,   0, 0,  0,    0,   1,   1, 0, 50,   50,   1,   0,   0,   0,    0, 0,   0,  0, 0,    0);
      tbl[14] = mk(0,   1, 0,  3,    4,   1,   1, 0, 50,   50,   1,   1,   0,   1,    1, 7,   0,  0, 0,    0);

      // Reset held for two cycles with a request present: nothing may issue.
      drive(1'b1, 1'b1, 3'd3, 32'd1, 32'd2, 1'b0, 1'b1, 3'd4, 32'd3, 32'd4, 1'b0);
      for (int c = 0; c < 2; c++) begin
         #4;
         chk("reset_rdy0", 32'(req_ready_0), 32'd0);
         chk("reset_rdy1", 32'(req_ready_1), 32'd0);
         chk("reset_busy", 32'(busy), 32'd0);
         chk("reset_alu_op", 32'(alu_op), 32'd0);
         chk("reset_alu_a", alu_a, 32'd0);
         @(posedge CLK); #1;
      end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      #3;
      chk("idle_v0", 32'(rsp_valid_0), 32'd0);
      chk("idle_v1", 32'(rsp_valid_1), 32'd0);
      chk("idle_r0", rsp_result_0, 32'd0);
      chk("idle_r1", rsp_result_1, 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_alu_op", 32'(alu_op), 32'd0);
      @(posedge CLK); #1;

      // Table phase.
      for (int i = 0; i < 15; i++) begin
         logic [2:0]  eop;
         logic [31:0] ea, eb;
         drive(tbl[i].rst, tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].rr0,
               tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rr1);
         eop = '0; ea = '0; eb = '0;
         if (tbl[i].e_rdy0) begin
            eop = tbl[i].op0; ea = tbl[i].a0; eb = tbl[i].b0;
         end else if (tbl[i].e_rdy1) begin
            eop = tbl[i].op1; ea = tbl[i].a1; eb = tbl[i].b1;
         end
         #3;
         chk($sformatf("t%0d_rdy0", i), 32'(req_ready_0), 32'(tbl[i].e_rdy0));
         chk($sformatf("t%0d_rdy1", i), 32'(req_ready_1), 32'(tbl[i].e_rdy1));
         chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("t%0d_alu_op", i), 32'(alu_op), 32'(eop));
         chk($sformatf("t%0d_alu_a", i), alu_a, ea);
         chk($sformatf("t%0d_alu_b", i), alu_b, eb);
         @(posedge CLK); #1;
         chk($sformatf("t%0d_v0", i), 32'(rsp_valid_0), 32'(tbl[i].e_v0));
         chk($sformatf("t%0d_r0", i), rsp_result_0, tbl[i].e_r0);
         chk($sformatf("t%0d_z0", i), 32'(rsp_zero_0), 32'(tbl[i].e_z0));
         chk($sformatf("t%0d_v1", i), 32'(rsp_valid_1), 32'(tbl[i].e_v1));
         chk($sformatf("t%0d_r1", i), rsp_result_1, tbl[i].e_r1);
         chk($sformatf("t%0d_z1", i), 32'(rsp_zero_1), 32'(tbl[i].e_z1));
      end

      // Hand sequence: a held response survives several idle cycles untouched.
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge CLK);
      #1;
      chk("hold_v0", 32'(rsp_valid_0), 32'd1);
      chk("hold_r0", rsp_result_0, 32'd7);

      // Random phase: reset first, then model-checked traffic.
      drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      @(posedge CLK); #1;
      for (int n = 0; n < 2; n++) begin
         mv[n] = 1'b0; mr[n] = '0; mz[n] = 1'b0; pv[n] = 1'b0;
         pop[n] = '0; pa[n] = '0; pb[n] = '0;
      end
      mprio = 0;

      for (int c = 0; c < 600; c++) begin
         logic rst;
         logic el[2];
         int g;
         logic [2:0]  eop;
         logic [31:0] ea, eb;
         for (int n = 0; n < 2; n++) begin
            if (!pv[n] && $urandom_range(0, 2) != 0) begin
               pv[n]  = 1'b1;
               pop[n] = 3'($urandom_range(0, 7));
               pa[n]  = $urandom;
               pb[n]  = ($urandom_range(0, 3) == 0) ? pa[n] : $urandom;
            end
            rr[n] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 49) == 0);
         drive(rst, pv[0], pop[0], pa[0], pb[0], rr[0], pv[1], pop[1], pa[1], pb[1], rr[1]);

         for (int n = 0; n < 2; n++) el[n] = pv[n] && (!mv[n] || rr[n]);
         g = -1;
         if (!rst) begin
            if (el[0] && el[1]) g = mprio;
            else if (el[0]) g = 0;
            else if (el[1]) g = 1;
         end
         eop = '0; ea = '0; eb = '0;
         if (g >= 0) begin
            eop = pop[g]; ea = pa[g]; eb = pb[g];
         end
         #3;
         chk("rnd_rdy0", 32'(req_ready_0), 32'(g == 0));
         chk("rnd_rdy1", 32'(req_ready_1), 32'(g == 1));
         chk("rnd_busy", 32'(busy), 32'(g >= 0));
         chk("rnd_alu_op", 32'(alu_op), 32'(eop));
         chk("rnd_alu_a", alu_a, ea);
         chk("rnd_alu_b", alu_b, eb);
         chk("rnd_v0", 32'(rsp_valid_0), 32'(mv[0]));
         chk("rnd_r0", rsp_result_0, mr[0]);
         chk("rnd_z0", 32'(rsp_zero_0), 32'(mz[0]));
         chk("rnd_v1", 32'(rsp_valid_1), 32'(mv[1]));
         chk("rnd_r1", rsp_result_1, mr[1]);
         chk("rnd_z1", 32'(rsp_zero_1), 32'(mz[1]));
         @(posedge CLK); #1;

         if (rst) begin
            for (int n = 0; n < 2; n++) begin
               mv[n] = 1'b0; mr[n] = '0; mz[n] = 1'b0;
            end
            mprio = 0;
         end else begin
            for (int n = 0; n < 2; n++) begin
               if (g == n) begin
                  mr[n] = alu_f(pop[n], pa[n], pb[n]);
                  mz[n] = (mr[n] == 32'd0);
                  mv[n] = 1'b1;
                  pv[n] = 1'b0;
               end else if (rr[n]) begin
                  mv[n] = 1'b0;
               end
            end
            if (g >= 0) mprio = 1 - g;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
